// File: rtl/tdm_pkg.sv
// Shared constants and state type for the TDM demultiplexer.
// Optional build macro: TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to each frame.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

`ifdef TDM_DEMUX_PARITY_EN
  // Counter runs 0..8; index 8 is the parity slot.
  localparam int unsigned CTR_W     = 4;
  localparam int unsigned LAST_SLOT = NUM_SLOTS;
  // All eight data bits are buffered until the parity bit arrives.
  localparam int unsigned SHADOW_W  = NUM_SLOTS;
`else
  localparam int unsigned CTR_W     = SLOT_W;
  localparam int unsigned LAST_SLOT = NUM_SLOTS - 1;
  // The slot-7 bit goes straight to dout, so only slots 0..6 are buffered.
  localparam int unsigned SHADOW_W  = NUM_SLOTS - 1;
`endif

  typedef enum logic [0:0] {
    HUNT,
    LOCKED
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: clear, load-to-1, and increment with wrap at Last.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned Width = CTR_W,
  parameter int unsigned Last  = LAST_SLOT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_one_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Next count: clear has priority over load, load over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_one_i) begin
      cnt_d = Width'(1);
    end else if (inc_i) begin
      cnt_d = (cnt_q == Width'(Last)) ? '0 : cnt_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux8.sv
// Serial TDM to 8-bit parallel demultiplexer with frame-sync hunting and lock tracking.
// Optional build macro: TDM_DEMUX_PARITY_EN (9-slot frames with even parity, par_err active).
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter logic [NUM_SLOTS-1:0] RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NUM_SLOTS-1:0] dout,
  output logic                 dout_valid,
  output logic [SLOT_W-1:0]    slot,
  output logic                 locked,
  output logic                 sync_err,
  output logic                 par_err
);

  state_t                state_d, state_q;
  logic [SHADOW_W-1:0]   shadow_d, shadow_q;
  logic [NUM_SLOTS-1:0]  dout_d, dout_q;
  logic                  dout_valid_d, dout_valid_q;
  logic                  sync_err_d, sync_err_q;
  logic                  ctr_clr, ctr_load, ctr_inc;
  logic [CTR_W-1:0]      cnt;
`ifdef TDM_DEMUX_PARITY_EN
  logic                  par_err_d, par_err_q;
`endif

  tdm_slot_ctr #(
    .Width (CTR_W),
    .Last  (LAST_SLOT)
  ) u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ctr_clr),
    .load_one_i (ctr_load),
    .inc_i      (ctr_inc),
    .cnt_o      (cnt)
  );

  // Next-state, shadow capture and frame completion.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    ctr_clr      = 1'b0;
    ctr_load     = 1'b0;
    ctr_inc      = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_err_d    = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        // Hold the counter at 0 until a frame_sync is seen.
        ctr_clr = 1'b1;
        if (din_valid && frame_sync) begin
          shadow_d    = '0;
          shadow_d[0] = din;
          ctr_clr     = 1'b0;
          ctr_load    = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (frame_sync && (cnt != '0)) begin
            // Misplaced sync: restart the frame on this bit, keep dout.
            sync_err_d  = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = din;
            ctr_load    = 1'b1;
          end else begin
            ctr_inc = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            if (cnt == CTR_W'(LAST_SLOT)) begin
              // Even parity: data bits plus parity bit must hold an even count of ones.
              if (^{shadow_q, din} == 1'b0) begin
                dout_d       = shadow_q;
                dout_valid_d = 1'b1;
              end else begin
                par_err_d = 1'b1;
              end
            end else begin
              shadow_d[cnt[SLOT_W-1:0]] = din;
            end
`else
            if (cnt == CTR_W'(LAST_SLOT)) begin
              dout_d       = {din, shadow_q};
              dout_valid_d = 1'b1;
            end else begin
              shadow_d[cnt] = din;
            end
`endif
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State, frame buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shadow_q     <= '0;
      dout_q       <= RST_VAL;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
  // The parity slot reports as slot 0.
  assign slot    = (cnt == CTR_W'(LAST_SLOT)) ? '0 : cnt[SLOT_W-1:0];
`else
  assign par_err = 1'b0;
  assign slot    = cnt;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8.
// Optional build macro: TDM_DEMUX_PARITY_EN (bench appends parity bits and runs parity cases).
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;
  logic       par_err;

  int errors = 0;
  int checks = 0;
  int dv_cnt = 0, se_cnt = 0, pe_cnt = 0;
  int dv_long = 0, se_long = 0;
  logic dv_prev = 1'b0, se_prev = 1'b0;

  tdm_demux8 #(
    .RST_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dout_valid) begin
      dv_cnt++;
      if (dv_prev) dv_long++;
    end
    if (sync_err) begin
      se_cnt++;
      if (se_prev) se_long++;
    end
    if (par_err) pe_cnt++;
    dv_prev = dout_valid;
    se_prev = sync_err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one valid bit for one cycle, starting and ending on a falling edge.
  task automatic send_bit(input logic b, input logic fs);
    din        = b;
    din_valid  = 1'b1;
    frame_sync = fs;
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send a full frame, slot 0 first, with an optional idle gap after every third bit.
  task automatic send_byte(input logic [7:0] v, input logic fs_first, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i], fs_first && (i == 0));
      if ((gap > 0) && (i % 3 == 2)) idle(gap);
    end
`ifdef TDM_DEMUX_PARITY_EN
    send_bit(^v, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] f1;
    f1 = 8'hF1;
    idle(2);
    // Reset state.
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_slot", slot, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_par_err", par_err, 0);
    rst_n = 1'b1;
    idle(1);

    // Bits without frame_sync are ignored while hunting.
    send_byte(8'hFF, 1'b0, 0);
    idle(2);
    check("hunt_locked", locked, 0);
    check("hunt_dout", dout, 8'h00);
    check("hunt_dv_cnt", dv_cnt, 0);
    check("hunt_slot", slot, 0);

    // Frame F1 with sync on bit 0; dout_valid one cycle after the last bit.
    send_bit(f1[0], 1'b1);
    check("lock_after_sync", locked, 1);
    check("slot_after_sync", slot, 1);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) check("no_early_dv", dout_valid, 0);
      send_bit(f1[i], 1'b0);
    end
`ifdef TDM_DEMUX_PARITY_EN
    check("slot_during_parity", slot, 0);
    send_bit(1'b1, 1'b0);
`endif
    check("f1_dout_valid", dout_valid, 1);
    check("f1_dout", dout, 8'hF1);
    idle(2);
    check("f1_dv_cleared", dout_valid, 0);
    check("f1_dv_cnt", dv_cnt, 1);
    check("f1_locked", locked, 1);
    check("f1_slot_wrap", slot, 0);

    // Misplaced sync restarts the frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("slot_after_3", slot, 3);
    send_bit(1'b1, 1'b1);
    idle(2);
    check("se_cnt", se_cnt, 1);
    check("se_slot", slot, 1);
    check("se_dout_hold", dout, 8'hF1);
    check("se_dv_cnt", dv_cnt, 1);
    check("se_locked", locked, 1);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    send_bit(1'b1, 1'b0);
`endif
    idle(2);
    check("se_frame_dout", dout, 8'h01);
    check("se_frame_dv_cnt", dv_cnt, 2);

    // Back-to-back frames with gaps; sync on slot 0 while locked is not an error.
    send_byte(8'hA5, 1'b1, 2);
    check("a5_dout", dout, 8'hA5);
    send_byte(8'h3C, 1'b0, 2);
    idle(2);
    check("3c_dout", dout, 8'h3C);
    check("b2b_dv_cnt", dv_cnt, 4);
    check("b2b_se_cnt", se_cnt, 1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_locked", locked, 0);
    check("async_rst_slot", slot, 0);
    check("async_rst_dout", dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("rst_mid_dv_cnt", dv_cnt, 4);
    check("rst_mid_se_cnt", se_cnt, 1);
    send_byte(8'h0F, 1'b1, 0);
    idle(2);
    check("0f_dout", dout, 8'h0F);
    check("0f_dv_cnt", dv_cnt, 5);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity: par_err pulse, dout unchanged, no dout_valid.
    for (int i = 0; i < 8; i++) send_bit(f1[i], i == 0);
    send_bit(1'b0, 1'b0);
    idle(2);
    check("par_err_cnt", pe_cnt, 1);
    check("par_dout_hold", dout, 8'h0F);
    check("par_dv_cnt", dv_cnt, 5);
`else
    check("par_err_tied", pe_cnt, 0);
`endif

    check("dv_single_cycle", dv_long, 0);
    check("se_single_cycle", se_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
